uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmit engine sitting directly downstream of the UART TX FIFO, which the APB register block fills through tx_data writes.
- Pops one byte at a time and serialises it onto the tx line: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
- Bit timing, parity mode and stop-bit count come from the register block's BAUD/PARITY_MODE/STOP_BITS outputs.
- Drives TX_DONE back to the register block as a one-cycle pulse per completed frame.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- BAUD_WIDTH, 32, width of the baud divisor input.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- BAUD  input  BAUD_WIDTH  clock cycles per bit; 0 is treated as 1
- PARITY_MODE  input  2  00 none, 01 odd, 10 even, 11 none
- STOP_BITS  input  2  00 one stop bit, any other value two stop bits
- tx_fifo_empty  input  1  TX FIFO empty flag
- tx_fifo_dout  input  DATA_WIDTH  FIFO head word (first-word-fall-through, valid when !tx_fifo_empty)
- tx_fifo_read_en  output  1  one-cycle pop strobe to the FIFO
- tx  output  1  serial line, idle high
- tx_busy  output  1  high from pop until the end of the last stop bit
- tx_done_tick  output  1  one-cycle pulse at the end of the last stop bit

Behaviour:
- Reset values: tx=1, tx_fifo_read_en=0, tx_busy=0, tx_done_tick=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: on the next edge, tx=1, the frame is abandoned, and tx_done_tick is not pulsed. The popped byte is lost.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If !tx_fifo_empty, assert tx_fifo_read_en for exactly one cycle.
  - In the same cycle, latch tx_fifo_dout, BAUD (0 mapped to 1), PARITY_MODE and STOP_BITS.
  - Go to START on the next edge.
- Latched settings are used for the whole frame; input changes mid-frame take effect from the next frame.
- Bit timing:
  - A bit counter runs 0..BAUD_latched-1.
  - Each state holds for exactly BAUD_latched cycles per bit.
  - tx is registered and changes only on bit boundaries.
- START: tx=0 for one bit time, then go to DATA.
- DATA:
  - Shift out DATA_WIDTH bits, LSB first, one bit time each.
  - A 3-bit index counter runs 0..DATA_WIDTH-1.
  - Afterwards go to PARITY if the latched mode is 01 or 10, else to STOP.
- PARITY:
  - Odd mode: bit = ~^data. Even mode: bit = ^data.
  - One bit time, then go to STOP.
- STOP:
  - tx=1 for one bit time (STOP_BITS=00) or two bit times (otherwise).
  - In the final cycle of the last stop bit, pulse tx_done_tick for one cycle.
- Back-to-back frames:
  - In that same final cycle, if !tx_fifo_empty, assert tx_fifo_read_en, latch the next byte and settings, and go directly to START. No idle bit is inserted.
  - Otherwise go to IDLE.
- Frame length in cycles: BAUD_latched × (1 + DATA_WIDTH + P + S), where P = 1 if parity is enabled else 0, and S = 1 or 2.
- tx_busy:
  - Goes high in the cycle after the pop.
  - Drops in the cycle after tx_done_tick, unless a back-to-back pop occurred.
- tx_fifo_read_en is never asserted while tx_fifo_empty=1, and never more than once per frame.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- When defined:
  - Adds input send_break (1 bit).
  - While send_break=1 and state=IDLE, tx is driven 0 and no FIFO pops occur.
  - If send_break rises mid-frame, the current frame completes normally (including tx_done_tick); break starts at IDLE.
  - When send_break deasserts, tx returns to 1, and the FSM waits one full bit time (mark) before it may pop again.
- When undefined: the port is absent and tx is never held low outside START/data/parity bits.

Test Plan:
- BAUD=4, PARITY_MODE=00, STOP_BITS=00, FIFO holds 0x55 -> one read_en pulse. tx pattern 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles wide (40 cycles). tx_done_tick in cycle 40; tx_busy then low.
- BAUD=2, 0xA5 with PARITY_MODE=10 then 01 -> parity bit 0 (even) and 1 (odd). Frame 11 bits = 22 cycles each.
- BAUD=3, STOP_BITS=01, FIFO holds 0x00 and 0xFF -> two frames of 11 bits (33 cycles each) with no gap. The second read_en coincides with the first tx_done_tick; exactly two tx_done_tick pulses.
- BAUD=0, 0x81, no parity -> each bit lasts 1 cycle. Frame is 10 cycles: 0,1,0,0,0,0,0,0,1,1.
- BAUD=8, assert reset during DATA bit 3 -> tx=1 on the next edge, no tx_done_tick, FSM in IDLE. A later byte transmits correctly.
- UART_TX_BREAK_EN defined: assert send_break for 50 cycles with FIFO non-empty and BAUD=4 -> tx low for 50 cycles with no pop. After release, tx high for 4 cycles, then the pop and start bit follow.

Source files
------------

// File: rtl/uart_tx_if.sv
// TX FIFO read handshake between the UART transmit engine and its FIFO.
// master = transmit engine (issues pops), slave = FIFO (supplies the head word).
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  tx_fifo_empty;
  logic [DATA_WIDTH-1:0] tx_fifo_dout;
  logic                  tx_fifo_read_en;

  modport master (
    input  tx_fifo_empty,
    input  tx_fifo_dout,
    output tx_fifo_read_en
  );

  modport slave (
    output tx_fifo_empty,
    output tx_fifo_dout,
    input  tx_fifo_read_en
  );

endinterface

// File: rtl/uart_tx.sv
// UART serial transmit engine: pops bytes from the TX FIFO and frames them as start/data/parity/stop.
// Optional line-break generation is compiled in with the UART_TX_BREAK_EN macro.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BAUD_WIDTH-1:0] BAUD,
  input  logic [1:0]            PARITY_MODE,
  input  logic [1:0]            STOP_BITS,
`ifdef UART_TX_BREAK_EN
  input  logic                  send_break,
`endif
  uart_tx_if.master             fifo,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [BAUD_WIDTH-1:0] BAUD_ONE = {{(BAUD_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [BAUD_WIDTH-1:0] bit_cnt;
  logic [BAUD_WIDTH-1:0] bit_cnt_next;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic [IDX_W-1:0]      idx_inc;
  logic                  stop_cnt;
  logic                  stop_cnt_next;
  logic                  tx_next;
  logic                  busy_next;

  logic [DATA_WIDTH-1:0] data_reg;
  logic [BAUD_WIDTH-1:0] baud_reg;
  logic [1:0]            parity_reg;
  logic [1:0]            stop_reg;

  logic [BAUD_WIDTH-1:0] baud_live;
  logic [BAUD_WIDTH-1:0] baud_last;
  logic                  bit_end;
  logic                  parity_en;
  logic                  parity_bit;
  logic                  chain_ok;
  logic                  read_en_c;
  logic                  done_c;
  logic                  load;

`ifdef UART_TX_BREAK_EN
  logic                  mark_pending;
  logic                  mark_next;
  logic [BAUD_WIDTH-1:0] baud_live_last;
`endif

  // A divisor of zero would never end a bit, so it runs as one cycle per bit.
  assign baud_live  = (BAUD == '0) ? BAUD_ONE : BAUD;
  assign baud_last  = baud_reg - BAUD_ONE;
  assign bit_end    = (bit_cnt == baud_last);
  assign idx_inc    = idx + 1'b1;
  assign parity_en  = (parity_reg == 2'b01) || (parity_reg == 2'b10);
  assign parity_bit = (parity_reg == 2'b01) ? ~^data_reg : ^data_reg;

`ifdef UART_TX_BREAK_EN
  assign baud_live_last = baud_live - BAUD_ONE;
  assign chain_ok       = !fifo.tx_fifo_empty && !send_break;
`else
  assign chain_ok       = !fifo.tx_fifo_empty;
`endif

  // Strobes are combinational so a pop and a done tick share the last stop cycle.
  assign fifo.tx_fifo_read_en = read_en_c & ~reset;
  assign tx_done_tick         = done_c & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      idx        <= '0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      data_reg   <= '0;
      baud_reg   <= '0;
      parity_reg <= 2'b00;
      stop_reg   <= 2'b00;
`ifdef UART_TX_BREAK_EN
      mark_pending <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      idx      <= idx_next;
      stop_cnt <= stop_cnt_next;
      tx       <= tx_next;
      tx_busy  <= busy_next;
`ifdef UART_TX_BREAK_EN
      mark_pending <= mark_next;
`endif
      if (load) begin
        data_reg   <= fifo.tx_fifo_dout;
        baud_reg   <= baud_live;
        parity_reg <= PARITY_MODE;
        stop_reg   <= STOP_BITS;
      end
    end
  end

  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    idx_next      = idx;
    stop_cnt_next = stop_cnt;
    tx_next       = tx;
    busy_next     = tx_busy;
    read_en_c     = 1'b0;
    done_c        = 1'b0;
    load          = 1'b0;
`ifdef UART_TX_BREAK_EN
    mark_next     = mark_pending;
`endif

    case (state)
      IDLE: begin
        tx_next      = 1'b1;
        bit_cnt_next = '0;
`ifdef UART_TX_BREAK_EN
        // After a break the line must show one full mark bit before the next start bit.
        if (send_break) begin
          tx_next   = 1'b0;
          mark_next = 1'b1;
        end else if (mark_pending) begin
          if (bit_cnt == baud_live_last) begin
            mark_next = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else
`endif
        if (!fifo.tx_fifo_empty) begin
          read_en_c  = 1'b1;
          load       = 1'b1;
          busy_next  = 1'b1;
          tx_next    = 1'b0;
          state_next = START;
        end
      end

      START: begin
        if (bit_end) begin
          bit_cnt_next = '0;
          idx_next     = '0;
          tx_next      = data_reg[0];
          state_next   = DATA;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          bit_cnt_next = '0;
          if (idx == IDX_LAST) begin
            if (parity_en) begin
              tx_next    = parity_bit;
              state_next = PARITY;
            end else begin
              tx_next       = 1'b1;
              stop_cnt_next = 1'b0;
              state_next    = STOP;
            end
          end else begin
            idx_next = idx_inc;
            tx_next  = data_reg[idx_inc];
          end
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          bit_cnt_next  = '0;
          tx_next       = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = STOP;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          bit_cnt_next = '0;
          if (stop_cnt || (stop_reg == 2'b00)) begin
            done_c = 1'b1;
            // Chain straight into the next start bit with no idle gap.
            if (chain_ok) begin
              read_en_c  = 1'b1;
              load       = 1'b1;
              tx_next    = 1'b0;
              state_next = START;
            end else begin
              busy_next  = 1'b0;
              state_next = IDLE;
            end
          end else begin
            stop_cnt_next = 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: table-driven frames plus chained, reset and break sequences.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] baud = 32'd4;
  logic [1:0]    parity_mode = 2'b00;
  logic [1:0]    stop_bits = 2'b00;
  logic          tx;
  logic          tx_busy;
  logic          tx_done_tick;
`ifdef UART_TX_BREAK_EN
  logic          send_break = 1'b0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  uart_tx_if #(.DATA_WIDTH(DW)) fif ();

  // Small FIFO model: the bench writes entries, the DUT's read strobe advances the read pointer.
  logic [DW-1:0] fifo_mem [0:15];
  logic [3:0]    wr_ptr = 4'd0;
  logic [3:0]    rd_ptr = 4'd0;

  assign fif.tx_fifo_empty = (wr_ptr == rd_ptr);
  assign fif.tx_fifo_dout  = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (fif.tx_fifo_read_en) rd_ptr <= rd_ptr + 4'd1;
  end

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .BAUD_WIDTH(BW)) dut (
    .clk          (clk),
    .reset        (reset),
    .BAUD         (baud),
    .PARITY_MODE  (parity_mode),
    .STOP_BITS    (stop_bits),
`ifdef UART_TX_BREAK_EN
    .send_break   (send_break),
`endif
    .fifo         (fif),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  typedef struct {
    string      name;
    logic [31:0] baud;
    int         bit_len;
    logic [1:0] parity;
    logic [1:0] stop;
    logic [7:0] data;
    logic [11:0] frame;
    int         nbits;
    bit         scramble;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [1:0] p, input logic [1:0] s);
    baud        = b;
    parity_mode = p;
    stop_bits   = s;
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic waitPop(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (fif.tx_fifo_read_en) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput({name, "_pop"}, 32'(found), 32'd1);
  endtask

  // Entered at the negedge of the pop cycle; checks every cycle of the frame that follows.
  task automatic runFrame(input string name, input logic [11:0] frame, input int nbits,
                          input int bit_len, input bit expect_chain, input bit scramble);
    bit last;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < bit_len; c++) begin
        @(negedge clk);
        if (scramble && b == 0 && c == 0) applyStimulus(baud + 32'd3, ~parity_mode, ~stop_bits);
        last = (b == nbits - 1) && (c == bit_len - 1);
        checkOutput($sformatf("%s_tx_b%0d_c%0d", name, b, c), 32'(tx), 32'(frame[b]));
        checkOutput($sformatf("%s_busy_b%0d", name, b), 32'(tx_busy), 32'd1);
        checkOutput($sformatf("%s_done_b%0d_c%0d", name, b, c), 32'(tx_done_tick), 32'(last));
        checkOutput($sformatf("%s_rden_b%0d_c%0d", name, b, c), 32'(fif.tx_fifo_read_en),
                    32'(last && expect_chain));
      end
    end
    if (!expect_chain) begin
      @(negedge clk);
      checkOutput({name, "_idle_busy"}, 32'(tx_busy), 32'd0);
      checkOutput({name, "_idle_tx"}, 32'(tx), 32'd1);
      checkOutput({name, "_idle_done"}, 32'(tx_done_tick), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;

    // Frames LSB = first bit on the line: start, data LSB-first, parity, stops.
    vecs[0] = '{"v55",  32'd4, 4, 2'b00, 2'b00, 8'h55, 12'h2AA, 10, 1'b0};
    vecs[1] = '{"vA5e", 32'd2, 2, 2'b10, 2'b00, 8'hA5, 12'h54A, 11, 1'b1};
    vecs[2] = '{"vA5o", 32'd2, 2, 2'b01, 2'b00, 8'hA5, 12'h74A, 11, 1'b0};
    vecs[3] = '{"v81",  32'd0, 1, 2'b00, 2'b00, 8'h81, 12'h302, 10, 1'b0};
    vecs[4] = '{"v3C",  32'd1, 1, 2'b11, 2'b01, 8'h3C, 12'h678, 11, 1'b0};
    vecs[5] = '{"v01",  32'd2, 2, 2'b01, 2'b10, 8'h01, 12'hC02, 12, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_done", 32'(tx_done_tick), 32'd0);
    checkOutput("rst_rden", 32'(fif.tx_fifo_read_en), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_tx", 32'(tx), 32'd1);

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      applyStimulus(vecs[v].baud, vecs[v].parity, vecs[v].stop);
      checkOutput({vecs[v].name, "_pre_busy"}, 32'(tx_busy), 32'd0);
      pushByte(vecs[v].data);
      #1;
      waitPop(vecs[v].name);
      runFrame(vecs[v].name, vecs[v].frame, vecs[v].nbits, vecs[v].bit_len, 1'b0, vecs[v].scramble);
    end

    // Two queued bytes go out back to back with the second pop on the first done tick.
    @(negedge clk);
    applyStimulus(32'd3, 2'b00, 2'b01);
    pushByte(8'h00);
    pushByte(8'hFF);
    #1;
    waitPop("b2b");
    runFrame("b2b0", 12'h600, 11, 3, 1'b1, 1'b0);
    runFrame("b2b1", 12'h7FE, 11, 3, 1'b0, 1'b0);
    checkOutput("b2b_fifo_empty", 32'(fif.tx_fifo_empty), 32'd1);

    // Reset in the middle of data bit 3 abandons the frame silently.
    @(negedge clk);
    applyStimulus(32'd8, 2'b00, 2'b00);
    pushByte(8'hA5);
    #1;
    waitPop("rstmid");
    repeat (8 + 24 + 3) @(negedge clk);
    checkOutput("rstmid_bit3_tx", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_done_in_rst", 32'(tx_done_tick), 32'd0);
    @(negedge clk);
    checkOutput("rstmid_tx", 32'(tx), 32'd1);
    checkOutput("rstmid_busy", 32'(tx_busy), 32'd0);
    checkOutput("rstmid_done", 32'(tx_done_tick), 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_done_tick || !tx || tx_busy) pulses++;
    end
    checkOutput("rstmid_quiet", 32'(pulses), 32'd0);
    checkOutput("rstmid_fifo_empty", 32'(fif.tx_fifo_empty), 32'd1);
    pushByte(8'h5A);
    #1;
    waitPop("rstafter");
    runFrame("rstafter", 12'h2B4, 10, 8, 1'b0, 1'b0);

`ifdef UART_TX_BREAK_EN
    // Break holds the line low without popping, then one mark bit precedes the start bit.
    @(negedge clk);
    applyStimulus(32'd4, 2'b00, 2'b00);
    send_break = 1'b1;
    pushByte(8'h55);
    #1;
    checkOutput("brk_rden_first", 32'(fif.tx_fifo_read_en), 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput($sformatf("brk_tx_%0d", i), 32'(tx), 32'd0);
      checkOutput($sformatf("brk_rden_%0d", i), 32'(fif.tx_fifo_read_en), 32'd0);
    end
    send_break = 1'b0;
    #1;
    checkOutput("brk_rel_rden", 32'(fif.tx_fifo_read_en), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mark_tx_%0d", i), 32'(tx), 32'd1);
      checkOutput($sformatf("mark_rden_%0d", i), 32'(fif.tx_fifo_read_en), 32'(i == 4));
    end
    runFrame("brk", 12'h2AA, 10, 4, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
